// File: rtl/div_pwm_pkg.sv
// Shared definitions for the divider-driven PWM generator.
package div_pwm_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] SEL_DIV2  = 2'b00;
  localparam logic [1:0] SEL_DIV4  = 2'b01;
  localparam logic [1:0] SEL_DIV8  = 2'b10;
  localparam logic [1:0] SEL_DIV16 = 2'b11;
endpackage

// File: rtl/div_pwm_gen_tick.sv
// Prescale select and rising-edge tick generation from the clock-divider outputs.
module tick_edge_sel
  import div_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dby2,
  input  logic       dby4,
  input  logic       dby8,
  input  logic       dby16,
  input  logic [1:0] sel,
  output logic       tick
);
  logic       src, src_q;
  logic [1:0] sel_q;

  always_comb begin
    src = dby16;
    case (sel)
      SEL_DIV2:  src = dby2;
      SEL_DIV4:  src = dby4;
      SEL_DIV8:  src = dby8;
      SEL_DIV16: src = dby16;
      default:   src = dby16;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= 1'b0;
      sel_q <= 2'b00;
    end else begin
      src_q <= src;
      sel_q <= sel;
    end
  end

  // src_q holds the previous source when sel moves, so that cycle's edge is untrustworthy
  assign tick = src & ~src_q & (sel == sel_q);
endmodule

// File: rtl/div_pwm_gen.sv
// PWM generator clocked by prescaler ticks; duty is double-buffered and
// swapped into the active register only at period wrap (or while disabled).
module div_pwm_gen
  import div_pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dby2,
  input  logic             dby4,
  input  logic             dby8,
  input  logic             dby16,
  input  logic [1:0]       sel,
  input  logic             en,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_load,
  output logic             pwm_out,
  output logic             period_end
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt, shadow, active, shadow_nxt;

  tick_edge_sel u_tick (
    .clk   (clk),
    .rst   (rst),
    .dby2  (dby2),
    .dby4  (dby4),
    .dby8  (dby8),
    .dby16 (dby16),
    .sel   (sel),
    .tick  (tick)
  );

  // A strobe coincident with the wrap tick bypasses straight into active
  assign shadow_nxt = duty_load ? duty : shadow;
  assign wrap       = en & tick & (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      pwm_out    <= en & (cnt < active);
      period_end <= wrap;
      if (!en) begin
        cnt    <= '0;
        active <= shadow_nxt;
      end else if (tick) begin
        cnt <= cnt + WIDTH'(1);
        if (wrap) active <= shadow_nxt;
      end
    end
  end
endmodule

// File: tb/tb_div_pwm_gen.sv
// Directed bench for div_pwm_gen with a behavioural 4-bit divider upstream.
module tb_div_pwm_gen;
  logic       clk, rst, en, duty_load;
  logic [1:0] sel;
  logic [7:0] duty;
  logic [3:0] div_cnt;
  logic       dby2, dby4, dby8, dby16;
  logic       pwm_out, period_end;
  int         n_checks = 0;
  int         n_fail   = 0;

  div_pwm_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .dby2(dby2), .dby4(dby4), .dby8(dby8), .dby16(dby16),
    .sel(sel), .en(en), .duty(duty), .duty_load(duty_load),
    .pwm_out(pwm_out), .period_end(period_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst)
    if (rst) div_cnt <= 4'd0;
    else     div_cnt <= div_cnt + 4'd1;

  assign dby2  = div_cnt[0];
  assign dby4  = div_cnt[1];
  assign dby8  = div_cnt[2];
  assign dby16 = div_cnt[3];

  // Steps at least one cycle, then stops on the first period_end
  task automatic wait_pe(input int bound, output bit ok, output int highs);
    int d;
    d = 0; highs = 0;
    do begin
      highs += int'(pwm_out);
      @(negedge clk);
      d++;
    end while (period_end !== 1'b1 && d < bound);
    ok = (period_end === 1'b1);
  endtask

  // Called while period_end is high; returns at the next period_end
  task automatic measure_period(output int len, output int highs, output bit ok);
    wait_pe(6000, ok, highs);
    len = 0;
    if (ok) len = -1;
  endtask

  task automatic measure(output int len, output int highs, output bit ok);
    int d;
    d = 0; highs = 0;
    do begin
      highs += int'(pwm_out);
      @(negedge clk);
      d++;
    end while (period_end !== 1'b1 && d < 6000);
    ok  = (period_end === 1'b1);
    len = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sel = 2'b00; duty = 8'd0; duty_load = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_checks++; if (period_end !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", period_end); end
    n_checks++; if (dut.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
    n_checks++; if (dut.shadow !== 8'd0) begin n_fail++; $display("FAIL reset_shadow: got %0d want 0", dut.shadow); end
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int highs, len;
    repeat (20) @(negedge clk);
    duty = 8'd64; duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    wait_pe(600, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_first_pe: no period_end within 600 clk"); end
    n_checks++; if (highs != 0) begin n_fail++; $display("FAIL basic_first_high: got %0d want 0", highs); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 512) begin n_fail++; $display("FAIL basic_len: got %0d want 512", len); end
    n_checks++; if (highs != 128) begin n_fail++; $display("FAIL basic_high: got %0d want 128", highs); end
  endtask

  task automatic test_sel11();
    bit ok; int highs, len;
    sel = 2'b11;
    repeat (5) @(negedge clk);
    duty = 8'd200; duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    wait_pe(5000, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sel11_pe: no period_end within 5000 clk"); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 4096) begin n_fail++; $display("FAIL sel11_len: got %0d want 4096", len); end
    n_checks++; if (highs != 3200) begin n_fail++; $display("FAIL sel11_high: got %0d want 3200", highs); end
  endtask

  task automatic test_strobes();
    bit ok; int highs, len;
    sel = 2'b00;
    wait_pe(5000, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL strobe_sync: no period_end within 5000 clk"); end
    repeat (100) @(negedge clk);
    duty = 8'd10; duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    repeat (3) @(negedge clk);
    duty = 8'd30; duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    wait_pe(600, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL strobe_pe: no period_end within 600 clk"); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 512) begin n_fail++; $display("FAIL strobe_len: got %0d want 512", len); end
    n_checks++; if (highs != 60) begin n_fail++; $display("FAIL strobe_last_wins: got %0d want 60", highs); end
    // Wrap tick is the cycle just before the next period_end
    repeat (511) @(negedge clk);
    duty = 8'd90; duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    n_checks++; if (period_end !== 1'b1) begin n_fail++; $display("FAIL bypass_align: got %b want 1", period_end); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 512) begin n_fail++; $display("FAIL bypass_len: got %0d want 512", len); end
    n_checks++; if (highs != 180) begin n_fail++; $display("FAIL bypass_high: got %0d want 180", highs); end
  endtask

  task automatic test_sel_switch();
    bit ok; int highs, n_before;
    int t_chg[$];
    logic [7:0] prev, cur, exp_c;
    repeat (50) @(negedge clk);
    prev = dut.cnt;
    n_before = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cur = dut.cnt;
      if (cur !== prev) begin
        exp_c = prev + 8'd1;
        n_checks++; if (cur !== exp_c) begin n_fail++; $display("FAIL switch_step: got %0d want %0d", cur, exp_c); end
        t_chg.push_back(i);
      end
      prev = cur;
      if (i == 10) begin
        sel = 2'b10;
        n_before = t_chg.size();
      end
    end
    for (int j = 1; j < t_chg.size(); j++) begin
      n_checks++;
      if (t_chg[j] - t_chg[j-1] < 2) begin n_fail++; $display("FAIL switch_gap: got %0d want >=2", t_chg[j] - t_chg[j-1]); end
    end
    n_checks++; if (t_chg.size() - n_before < 6) begin n_fail++; $display("FAIL switch_count: got %0d want >=6", t_chg.size() - n_before); end
    for (int j = n_before + 1; j < t_chg.size(); j++) begin
      n_checks++;
      if (t_chg[j] - t_chg[j-1] != 8) begin n_fail++; $display("FAIL switch_spacing: got %0d want 8", t_chg[j] - t_chg[j-1]); end
    end
    sel = 2'b00;
    wait_pe(3000, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL switch_resync: no period_end within 3000 clk"); end
  endtask

  task automatic test_en_low();
    bit ok; int highs, len, d, bad;
    repeat (100) @(negedge clk);
    en = 1'b0; duty = 8'd128;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || period_end !== 1'b0 || dut.cnt !== 8'd0) bad++;
      duty_load = (i == 10);
    end
    duty_load = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL en_low_idle: got %0d bad cycles want 0", bad); end
    d = 0;
    while (div_cnt[0] !== 1'b0 && d < 4) begin @(negedge clk); d++; end
    en = 1'b1;
    d = 0; highs = 0;
    while (period_end !== 1'b1 && d < 700) begin
      highs += int'(pwm_out);
      @(negedge clk);
      d++;
    end
    n_checks++; if (d != 512) begin n_fail++; $display("FAIL en_restart_len: got %0d want 512", d); end
    n_checks++; if (highs != 256) begin n_fail++; $display("FAIL en_restart_high: got %0d want 256", highs); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 512) begin n_fail++; $display("FAIL en_next_len: got %0d want 512", len); end
    n_checks++; if (highs != 256) begin n_fail++; $display("FAIL en_next_high: got %0d want 256", highs); end
  endtask

  task automatic test_async_reset();
    bit ok; int highs, len, d;
    d = 0;
    while (pwm_out !== 1'b1 && d < 600) begin @(negedge clk); d++; end
    n_checks++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got pwm %b want 1", pwm_out); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL arst_pwm: got %b want 0", pwm_out); end
    n_checks++; if (period_end !== 1'b0) begin n_fail++; $display("FAIL arst_pe: got %b want 0", period_end); end
    n_checks++; if (dut.cnt !== 8'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", dut.cnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_pe(600, ok, highs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL arst_first_pe: no period_end within 600 clk"); end
    n_checks++; if (highs != 0) begin n_fail++; $display("FAIL arst_first_high: got %0d want 0", highs); end
    measure(len, highs, ok);
    n_checks++; if (!ok || len != 512) begin n_fail++; $display("FAIL arst_len: got %0d want 512", len); end
    n_checks++; if (highs != 0) begin n_fail++; $display("FAIL arst_high: got %0d want 0", highs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel11();
    test_strobes();
    test_sel_switch();
    test_en_low();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_pwm_gen.md
# div_pwm_gen

Divider-driven PWM generator that sits directly downstream of the team's 4-bit clock divider. It takes the divider's dby2/dby4/dby8/dby16 outputs as same-domain data and selects one as a prescaler. It converts that signal's rising edges into single-cycle ticks and runs a WIDTH-bit PWM counter on those ticks. The duty value is double-buffered and takes effect only at period boundaries, so pwm_out never glitches mid-period.

## Interface
- WIDTH, 8, PWM counter/duty width; period = 2^WIDTH ticks
- clk  in  1  sole clock; divider outputs are registered on this same clock
- rst  in  1  asynchronous, active-high reset
- dby2, dby4, dby8, dby16  in  1 each  divider outputs (clk/2 … clk/16 square waves)
- sel  in  2  prescale select: 00=dby2, 01=dby4, 10=dby8, 11=dby16
- en  in  1  run enable
- duty  in  WIDTH  requested duty (high ticks per period)
- duty_load  in  1  single-cycle strobe: capture duty into shadow register
- pwm_out  out  1  PWM output, registered
- period_end  out  1  one-clk pulse per completed period, registered

## Operation
- Reset (async, rst=1) clears the following to 0: src_q, sel_q, cnt, shadow, active, pwm_out and period_end.
- Tick generation:
  - Each cycle, src = mux(sel), src_q <= src, sel_q <= sel.
  - tick = src & ~src_q & (sel == sel_q).
  - A cycle where sel differs from sel_q never produces a tick. This suppresses spurious edges when sel switches.
- Tick spacing at steady state: 2/4/8/16 clk for sel 00/01/10/11.
- Shadow register: duty_load=1 sets shadow <= duty. This is independent of en and tick. The last strobe before a boundary wins.
- Counter with en=1, on tick:
  - cnt <= cnt+1, wrapping modulo 2^WIDTH.
  - Wrap tick (cnt == 2^WIDTH-1): active <= shadow-next, and period_end is asserted next cycle.
  - shadow-next is the value shadow holds after this cycle's update. A duty_load coincident with the wrap tick therefore takes effect in the new period (bypass).
- en=0:
  - cnt <= 0 and active <= shadow-next, every cycle.
  - Ticks are ignored; pwm_out and period_end are driven 0.
  - On re-enable, counting restarts from 0 with the latest duty.
- pwm_out <= en & (cnt < active), where cnt and active are the pre-update (current) values.
- Duty boundaries:
  - duty=0: pwm_out is constantly 0.
  - duty=2^WIDTH-1: high for 255 of 256 ticks (WIDTH=8). 100% is not representable and this is intended.
- Reset mid-period forces an immediate restart: outputs go 0 asynchronously and the loaded duty is lost (shadow=0).

## Timing
- Source edge to tick: tick is combinational in the cycle in which src first reads 1 after reading 0.
- tick to cnt: cnt updates at the clock edge ending the tick cycle.
- cnt to pwm_out: 1 clk.
- Wrap: period_end is high for exactly 1 clk, in the cycle where cnt first reads 0 in the new period.
- duty_load to effect: no earlier than the next wrap. Worst case is a full period of 2^WIDTH × (2…16) clk.
- Period lengths, WIDTH=8: 512 clk (sel=00) to 4096 clk (sel=11).
- sel change: at most one tick lost. No extra tick is ever generated.
- en deassert: pwm_out is 0 from the next clk.

## Structure
- Shared package div_pwm_pkg holds:
  - sel encoding localparams SEL_DIV2/4/8/16 (2'b00–2'b11)
  - default WIDTH
- Sub-module tick_edge_sel (clk, rst, dby2..dby16, sel -> tick) owns the mux, src_q, sel_q and the suppression logic.
- The top level owns shadow, active, cnt, pwm_out and period_end.

## Test plan
- Reset, sel=00, en=1, duty_load with duty=64 before the first wrap.
  - First period (active=0): pwm_out stays 0.
  - After the first period_end: pwm_out is high for exactly 128 clk of each 512-clk period.
- sel=11, duty=200 loaded and active: period_end pulses are exactly 4096 clk apart, with pwm_out high 3200 clk per period.
- Two duty strobes, then a boundary-coincident strobe:
  - Mid-period, duty_load with 10, then with 30: the next period has high time 30 ticks; 10 never appears.
  - duty_load with 90 in the same cycle as the wrap tick: 90 applies in that new period.
- Switch sel 00→10 mid-period:
  - No cycle has two ticks within 2 clk of the switch.
  - Tick spacing becomes 8 clk within 8 clk.
  - cnt never skips a value.
- en low for 50 clk mid-period, with duty_load=128 while low:
  - pwm_out=0 throughout and cnt reads 0.
  - After re-enable, the first period has 128-tick high time and period_end comes after a full 256 ticks.
- Assert rst asynchronously mid-high-phase: pwm_out and period_end drop without waiting for clk. After release, behaviour matches a fresh reset (duty=0).
